// File: rtl/lsu_pkg.sv
// Shared state type, size codes and size helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [0:0] {IDLE, SPLIT} lsu_state_e;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;
  localparam logic [2:0] SZ_Q = 3'd4;

  function automatic logic [4:0] size_bytes(input logic [2:0] code);
    return 5'd1 << code;
  endfunction

  // Low-address mask for alignment; also the index of the last byte of a split.
  function automatic logic [3:0] size_mask(input logic [2:0] code);
    logic [4:0] n;
    n = size_bytes(code) - 5'd1;
    return n[3:0];
  endfunction

endpackage

// File: rtl/lsu_read_merge.sv
// Gather register for split loads: captures returned bytes by index, merges the
// final byte straight from memory and sign/zero-extends the assembled value.
module lsu_read_merge #(
  parameter int unsigned BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gather_we,
  input  logic [3:0]           gather_idx,
  input  logic [7:0]           rd_byte,
  input  logic [2:0]           size,
  input  logic                 is_unsigned,
  output logic [8*BYTES-1:0]   rdata
);
  import lsu_pkg::*;

  logic [BYTES-1:0][7:0] gather_q;
  logic [3:0]            last_idx;
  logic [7:0]            ext_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gather_q <= '0;
    end else if (gather_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (gather_idx == 4'(b)) gather_q[b] <= rd_byte;
      end
    end
  end

  assign last_idx = size_mask(size);
  // The final byte is always the most significant one, so it carries the sign.
  assign ext_byte = is_unsigned ? 8'h00 : {8{rd_byte[7]}};

  always_comb begin
    rdata = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (4'(b) < last_idx)       rdata[8*b +: 8] = gather_q[b];
      else if (4'(b) == last_idx) rdata[8*b +: 8] = rd_byte;
      else                        rdata[8*b +: 8] = ext_byte;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store request front end: forwards aligned accesses and, when LSU_SPLIT_EN
// is defined, splits misaligned ones into byte accesses (otherwise they error).
module load_store_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [2:0]       req_bytes,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_we,
  output logic [2:0]       mem_bytes,
  output logic             mem_rd_unsigned,
  output logic [WIDTH-1:0] mem_wr_data,
  input  logic [WIDTH-1:0] mem_rd_data,
  input  logic             mem_misaligned
);
  import lsu_pkg::*;

  localparam int unsigned MaxSize = $clog2(BYTES + 1) - 1;

  logic size_ok, misaligned;
  logic resp_valid_q, resp_valid_d;
  logic resp_err_q, resp_err_d;
  logic resp_load_q, resp_load_d;

  assign size_ok    = req_bytes <= 3'(MaxSize);
  assign misaligned = (req_addr[3:0] & size_mask(req_bytes)) != 4'd0;

`ifdef LSU_SPLIT_EN
  lsu_state_e       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic             we_q, uns_q;
  logic [2:0]       size_q;
  logic             err_q, err_d;
  logic             latch_en, gather_we;
  logic             resp_split_q, resp_split_d;
  logic [WIDTH-1:0] merged;
`endif

  always_comb begin
    req_ready       = 1'b1;
    mem_addr        = '0;
    mem_we          = 1'b0;
    mem_bytes       = 3'd0;
    mem_rd_unsigned = 1'b0;
    mem_wr_data     = '0;
    resp_valid_d    = 1'b0;
    resp_err_d      = 1'b0;
    resp_load_d     = 1'b0;
`ifdef LSU_SPLIT_EN
    state_d         = state_q;
    idx_d           = idx_q;
    err_d           = err_q;
    latch_en        = 1'b0;
    gather_we       = 1'b0;
    resp_split_d    = 1'b0;
    if (state_q == SPLIT) begin
      req_ready       = 1'b0;
      mem_addr        = addr_q + WIDTH'(idx_q);
      mem_we          = we_q;
      mem_bytes       = SZ_B;
      mem_rd_unsigned = 1'b1;
      mem_wr_data     = wdata_q >> {idx_q, 3'b000};
      // Byte idx-1 was issued last cycle and is on mem_rd_data now.
      gather_we       = !we_q;
      err_d           = err_q | mem_misaligned;
      if (idx_q == size_mask(size_q)) begin
        state_d      = IDLE;
        idx_d        = 4'd0;
        resp_valid_d = 1'b1;
        resp_err_d   = err_q | mem_misaligned;
        resp_split_d = !we_q;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end else
`endif
    if (req_valid) begin
      if (!size_ok) begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end else if (!misaligned) begin
        mem_addr        = req_addr;
        mem_we          = req_we;
        mem_bytes       = req_bytes;
        mem_rd_unsigned = req_unsigned;
        mem_wr_data     = req_wdata;
        resp_valid_d    = 1'b1;
        resp_err_d      = mem_misaligned;
        resp_load_d     = !req_we;
      end else begin
`ifdef LSU_SPLIT_EN
        mem_addr        = req_addr;
        mem_we          = req_we;
        mem_bytes       = SZ_B;
        mem_rd_unsigned = 1'b1;
        mem_wr_data     = req_wdata;
        latch_en        = 1'b1;
        err_d           = mem_misaligned;
        idx_d           = 4'd1;
        state_d         = SPLIT;
`else
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_load_q  <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_load_q  <= resp_load_d;
    end
  end

`ifdef LSU_SPLIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      err_q        <= 1'b0;
      resp_split_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 3'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      resp_split_q <= resp_split_d;
      if (latch_en) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_bytes;
      end
    end
  end

  lsu_read_merge #(
    .BYTES (BYTES)
  ) u_read_merge (
    .clk         (clk),
    .rst         (rst),
    .gather_we   (gather_we),
    .gather_idx  (idx_q - 4'd1),
    .rd_byte     (mem_rd_data[7:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rdata       (merged)
  );
`endif

  always_comb begin
    resp_rdata = '0;
    if (resp_valid_q && !resp_err_q) begin
`ifdef LSU_SPLIT_EN
      if (resp_split_q) resp_rdata = merged;
      else
`endif
      if (resp_load_q) resp_rdata = mem_rd_data;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Request-side front end for the memory manager's data port. It accepts load/store requests from the core execute stage over a valid/ready handshake and forwards naturally aligned accesses in one cycle. Misaligned accesses, which the memory manager cannot perform, are split into sequential single-byte accesses; read bytes are reassembled and sign- or zero-extended. It returns one response per request, with read data or an error flag.

## Interface
- `WIDTH`, 32: data/address width; multiple of 8, ≤128.
- `BYTES`, WIDTH/8: bytes per memory word.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  WIDTH  byte address.
- `req_bytes`  in  3  size code: 0=1B, 1=2B, 2=4B, 3=8B, 4=16B.
- `req_unsigned`  in  1  zero-extend the load result (else sign-extend).
- `req_wdata`  in  WIDTH  store data, LSB-justified.
- `resp_valid`  out  1  one-cycle response pulse; no back-pressure.
- `resp_rdata`  out  WIDTH  load result; 0 for stores and errors.
- `resp_err`  out  1  illegal size or unsupported misaligned access.
- `mem_addr`, `mem_we`, `mem_bytes[2:0]`, `mem_rd_unsigned`, `mem_wr_data[WIDTH-1:0]`  out  memory manager data-port request.
- `mem_rd_data`  in  WIDTH  memory manager read data, valid one cycle after the address.
- `mem_misaligned`  in  1  memory manager alignment flag.

## Operation
- Size legality: `req_bytes > log2(BYTES)` is illegal. Response at T+1 with `resp_err=1`. No memory access.
- Misaligned: `req_addr & ((1<<req_bytes)-1) != 0`.
- States: `IDLE`, `SPLIT`.
- `IDLE`:
  - `req_ready=1`.
  - Aligned, legal request: drive the mem port combinationally from the request in the accept cycle. `mem_we = req_we && req_valid`.
  - Misaligned request: latch addr, we, size, unsigned and wdata. Issue byte 0 in the same cycle (`mem_bytes=0`, `mem_rd_unsigned=1`). Set `idx=1` and go to `SPLIT`.
- `SPLIT`:
  - `req_ready=0`.
  - Each cycle, issue byte `idx`: address `addr+idx`, `mem_wr_data = wdata >> 8*idx`.
  - On `idx == N-1`, return to `IDLE`. N = `1<<size`.
  - Address addition wraps modulo 2^WIDTH.
- Read assembly: byte k, returned at issue+1, is stored at bits [8k+7:8k] of the gather register. The final byte is merged combinationally from `mem_rd_data`. The result is then extended from width 8N per the latched `unsigned`.
- If `mem_misaligned` is asserted during any issued access, that request's response has `resp_err=1`. This indicates an internal fault.
- When idle with no request, mem outputs are 0 and `mem_we=0`.
- Reset (any time, including mid-split):
  - State → `IDLE`; `resp_valid`, `resp_err` and `idx` → 0.
  - The pending split is abandoned.
  - Bytes already written stay written.
  - No response is issued for the aborted request.

## Timing
- Aligned load/store accepted at T: `resp_valid` at T+1. Sustains one request per cycle.
- Split accepted at T:
  - Byte k is issued at T+k.
  - `resp_valid` at T+N.
  - `req_ready` is low T+1..T+N-1 and high again at T+N, so a new request can be accepted in the response cycle.
- `resp_valid` and `resp_err` are registered. `resp_rdata` is combinational from `mem_rd_data` plus the gather register in the response cycle.
- Reset values: `req_ready=1` (the block is in `IDLE`), `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, all mem outputs 0.

## Configuration
- `LSU_SPLIT_EN` defined: misaligned accesses are split as described above.
- `LSU_SPLIT_EN` undefined:
  - No `SPLIT` state or gather register is built.
  - A misaligned request is accepted, responds at T+1 with `resp_err=1`, and makes no memory access (`mem_we=0`).
  - `req_ready` is constantly 1.

## Structure
- `lsu_pkg`: `lsu_state_e` (`IDLE`, `SPLIT`); size codes `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`, `SZ_Q`; function `size_bytes(code)`.
- Sub-module `lsu_read_merge`: gather register write-enable by byte index, final-byte merge, and sign/zero extension; parameterised by `BYTES`.

## Test plan
- Word 0xDEADBEEF at 0x10; load W from 0x10 at T → `resp_valid` at T+1, `rdata=0xDEADBEEF`, `err=0`.
- Byte 0x80 at 0x21; load B signed → 0xFFFFFF80; same with `unsigned=1` → 0x00000080.
- Store W 0x11223344 to 0x13 at T:
  - Byte stores 0x44 @0x13, 0x33 @0x14, 0x22 @0x15, 0x11 @0x16 at T..T+3.
  - `req_ready` low T+1..T+3; `resp_valid` at T+4.
  - Reading back W at 0x14 yields 0x??112233, where ?? is the unchanged byte at 0x17.
- Bytes 0x34 @0x21, 0x92 @0x22; load H signed from 0x21 → `resp_valid` at T+2, `rdata=0xFFFF9234`.
- `WIDTH=32`, `req_bytes=3` → `resp_err=1` at T+1, `mem_we` never high.
- Assert `rst` at T+2 of a 4-byte split store → bytes 0–1 written, bytes 2–3 untouched, no `resp_valid`, `req_ready=1` after reset.
